// File: rtl/asrv32_trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: opcode one-hot indices,
// mcause codes, FSM state encoding and the load/store alignment rule.
package asrv32_trap_ctrl_pkg;

   localparam int OPCODE_WIDTH = 6;
   localparam int OP_LOAD      = 0;
   localparam int OP_STORE     = 1;
   localparam int OP_BRANCH    = 2;
   localparam int OP_JAL       = 3;
   localparam int OP_JALR      = 4;
   localparam int OP_SYSTEM    = 5;

   // exception codes
   localparam logic [3:0] CAUSE_INST_MISALIGN  = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
   localparam logic [3:0] CAUSE_EBREAK         = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ECALL          = 4'd11;
   // interrupt codes
   localparam logic [3:0] CAUSE_M_SW           = 4'd3;
   localparam logic [3:0] CAUSE_M_TIMER        = 4'd7;
   localparam logic [3:0] CAUSE_M_EXT          = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRAIN    = 3'd1,
      ST_COMMIT   = 3'd2,
      ST_RET      = 3'd3,
      ST_REDIRECT = 3'd4
   } trap_state_t;

   // halfword needs addr[0]=0, word needs addr[1:0]=0, bytes never fault
   function automatic logic ls_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
      case (funct3)
         3'b001, 3'b101: ls_misaligned = addr[0];
         3'b010:         ls_misaligned = (addr != 2'b00);
         default:        ls_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/asrv32_trap_prio.sv
// Combinational trap detector: misalignment checks plus fixed-priority
// encoding of exceptions and enabled interrupts into a single cause.
module asrv32_trap_prio
   import asrv32_trap_ctrl_pkg::*;
(
   input  logic                    i_stage_en,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [2:0]              i_funct3,
   input  logic [31:0]             i_alu_result,
   input  logic                    i_branch_taken,
   input  logic                    i_is_inst_illegal,
   input  logic                    i_is_ecall,
   input  logic                    i_is_ebreak,
   input  logic [31:0]             i_pc,
   input  logic                    i_mstatus_mie,
   input  logic [2:0]              i_mie,
   input  logic                    i_external_interrupt,
   input  logic                    i_software_interrupt,
   input  logic                    i_timer_interrupt,
   output logic                    o_valid,
   output logic                    o_is_interrupt,
   output logic [3:0]              o_code,
   output logic [31:0]             o_tval
);

   logic w_inst_mis, w_load_mis, w_store_mis;

   assign w_inst_mis  = (i_opcode[OP_JAL] | i_opcode[OP_JALR] |
                         (i_opcode[OP_BRANCH] & i_branch_taken)) &
                        (i_alu_result[1:0] != 2'b00);
   assign w_load_mis  = i_opcode[OP_LOAD]  & ls_misaligned(i_funct3, i_alu_result[1:0]);
   assign w_store_mis = i_opcode[OP_STORE] & ls_misaligned(i_funct3, i_alu_result[1:0]);

   // exceptions first, then interrupts only when globally enabled
   always_comb begin
      o_valid        = 1'b0;
      o_is_interrupt = 1'b0;
      o_code         = 4'd0;
      o_tval         = 32'd0;
      if (i_stage_en) begin
         o_valid = 1'b1;
         if (w_inst_mis) begin
            o_code = CAUSE_INST_MISALIGN;
            o_tval = i_alu_result;
         end else if (i_is_inst_illegal) begin
            o_code = CAUSE_ILLEGAL;
         end else if (i_is_ebreak) begin
            o_code = CAUSE_EBREAK;
            o_tval = i_pc;
         end else if (i_is_ecall) begin
            o_code = CAUSE_ECALL;
         end else if (w_load_mis) begin
            o_code = CAUSE_LOAD_MISALIGN;
            o_tval = i_alu_result;
         end else if (w_store_mis) begin
            o_code = CAUSE_STORE_MISALIGN;
            o_tval = i_alu_result;
         end else if (i_mstatus_mie && i_mie[2] && i_external_interrupt) begin
            o_is_interrupt = 1'b1;
            o_code         = CAUSE_M_EXT;
         end else if (i_mstatus_mie && i_mie[0] && i_software_interrupt) begin
            o_is_interrupt = 1'b1;
            o_code         = CAUSE_M_SW;
         end else if (i_mstatus_mie && i_mie[1] && i_timer_interrupt) begin
            o_is_interrupt = 1'b1;
            o_code         = CAUSE_M_TIMER;
         end else begin
            o_valid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/asrv32_trap_ctrl.sv
// Trap sequencer: catches a trap or MRET at the MEMORYACCESS boundary,
// stalls, drains, pulses the CSR commit and redirects fetch.
module asrv32_trap_ctrl
   import asrv32_trap_ctrl_pkg::*;
#(
   parameter bit          VECTORED_EN  = 1'b1,
   parameter logic [31:0] TRAP_ADDRESS = 32'd0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_stage_en,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [2:0]              i_funct3,
   input  logic [31:0]             i_alu_result,
   input  logic                    i_branch_taken,
   input  logic                    i_is_inst_illegal,
   input  logic                    i_is_ecall,
   input  logic                    i_is_ebreak,
   input  logic                    i_is_mret,
   input  logic [31:0]             i_pc,
   input  logic                    i_mstatus_mie,
   input  logic [2:0]              i_mie,
   input  logic                    i_external_interrupt,
   input  logic                    i_software_interrupt,
   input  logic                    i_timer_interrupt,
   input  logic [31:0]             i_mtvec,
   input  logic [31:0]             i_mepc,
   input  logic                    i_pipe_idle,
   input  logic                    i_redirect_ack,
   output logic                    o_stall,
   output logic                    o_trap_commit,
   output logic                    o_mret_commit,
   output logic [31:0]             o_mepc,
   output logic [31:0]             o_mcause,
   output logic [31:0]             o_mtval,
   output logic                    o_redirect,
   output logic [31:0]             o_redirect_addr
);

   trap_state_t r_state;
   logic        r_stall, r_trap_commit, r_mret_commit, r_redirect;
   logic [31:0] r_mepc, r_mcause, r_mtval, r_redirect_addr;

   logic        w_trap_valid, w_is_int;
   logic [3:0]  w_code;
   logic [31:0] w_tval, w_base, w_trap_target;

   asrv32_trap_prio u_prio (
      .i_stage_en           (i_stage_en),
      .i_opcode             (i_opcode),
      .i_funct3             (i_funct3),
      .i_alu_result         (i_alu_result),
      .i_branch_taken       (i_branch_taken),
      .i_is_inst_illegal    (i_is_inst_illegal),
      .i_is_ecall           (i_is_ecall),
      .i_is_ebreak          (i_is_ebreak),
      .i_pc                 (i_pc),
      .i_mstatus_mie        (i_mstatus_mie),
      .i_mie                (i_mie),
      .i_external_interrupt (i_external_interrupt),
      .i_software_interrupt (i_software_interrupt),
      .i_timer_interrupt    (i_timer_interrupt),
      .o_valid              (w_trap_valid),
      .o_is_interrupt       (w_is_int),
      .o_code               (w_code),
      .o_tval               (w_tval)
   );

   // handler address from the live mtvec and the latched cause
   always_comb begin
      w_base        = i_mtvec & ~32'h3;
      if (w_base == 32'd0) w_base = TRAP_ADDRESS;
      w_trap_target = w_base;
      if (VECTORED_EN && (i_mtvec[1:0] == 2'b01) && r_mcause[31])
         w_trap_target = w_base + {26'd0, r_mcause[3:0], 2'b00};
   end

   // sequencing FSM; every output is a register updated on state entry
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= ST_IDLE;
         r_stall         <= 1'b0;
         r_trap_commit   <= 1'b0;
         r_mret_commit   <= 1'b0;
         r_redirect      <= 1'b0;
         r_mepc          <= 32'd0;
         r_mcause        <= 32'd0;
         r_mtval         <= 32'd0;
         r_redirect_addr <= 32'd0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_trap_valid) begin
                  r_state  <= ST_DRAIN;
                  r_stall  <= 1'b1;
                  r_mcause <= {w_is_int, 27'd0, w_code};
                  r_mepc   <= i_pc;
                  r_mtval  <= w_tval;
               end else if (i_stage_en && i_is_mret) begin
                  r_state       <= ST_RET;
                  r_stall       <= 1'b1;
                  r_mret_commit <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (i_pipe_idle) begin
                  r_state       <= ST_COMMIT;
                  r_trap_commit <= 1'b1;
               end
            end
            ST_COMMIT: begin
               r_state         <= ST_REDIRECT;
               r_trap_commit   <= 1'b0;
               r_redirect      <= 1'b1;
               r_redirect_addr <= w_trap_target;
            end
            ST_RET: begin
               r_state         <= ST_REDIRECT;
               r_mret_commit   <= 1'b0;
               r_redirect      <= 1'b1;
               r_redirect_addr <= i_mepc & ~32'h3;
            end
            ST_REDIRECT: begin
               if (i_redirect_ack) begin
                  r_state    <= ST_IDLE;
                  r_redirect <= 1'b0;
                  r_stall    <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_stall         = r_stall;
   assign o_trap_commit   = r_trap_commit;
   assign o_mret_commit   = r_mret_commit;
   assign o_redirect      = r_redirect;
   assign o_mepc          = r_mepc;
   assign o_mcause        = r_mcause;
   assign o_mtval         = r_mtval;
   assign o_redirect_addr = r_redirect_addr;

endmodule

// File: tb/tb_asrv32_trap_ctrl.sv
// Directed bench for the trap sequencer with hand-computed expectations.
module tb_asrv32_trap_ctrl;
   import asrv32_trap_ctrl_pkg::*;

   logic                    clk = 1'b0, rst_n = 1'b0;
   logic                    stage_en, branch_taken, illegal, ecall, ebreak, mret;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [2:0]              funct3, mie;
   logic [31:0]             alu, pc, mtvec, mepc_in;
   logic                    mstatus_mie, ext_irq, sw_irq, tim_irq, pipe_idle, ack;
   logic                    stall, trap_commit, mret_commit, redirect;
   logic [31:0]             mepc, mcause, mtval, redirect_addr;

   int n_vec = 0, n_err = 0, cyc;

   always #5 clk = ~clk;

   asrv32_trap_ctrl #(.VECTORED_EN(1'b1), .TRAP_ADDRESS(32'h0000_0800)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stage_en(stage_en), .i_opcode(opcode),
      .i_funct3(funct3), .i_alu_result(alu), .i_branch_taken(branch_taken),
      .i_is_inst_illegal(illegal), .i_is_ecall(ecall), .i_is_ebreak(ebreak),
      .i_is_mret(mret), .i_pc(pc), .i_mstatus_mie(mstatus_mie), .i_mie(mie),
      .i_external_interrupt(ext_irq), .i_software_interrupt(sw_irq),
      .i_timer_interrupt(tim_irq), .i_mtvec(mtvec), .i_mepc(mepc_in),
      .i_pipe_idle(pipe_idle), .i_redirect_ack(ack), .o_stall(stall),
      .o_trap_commit(trap_commit), .o_mret_commit(mret_commit), .o_mepc(mepc),
      .o_mcause(mcause), .o_mtval(mtval), .o_redirect(redirect),
      .o_redirect_addr(redirect_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stage_en = 0; opcode = '0; funct3 = 3'b000; alu = 0; branch_taken = 0;
      illegal = 0; ecall = 0; ebreak = 0; mret = 0; pc = 0;
      mstatus_mie = 0; mie = 3'b000; ext_irq = 0; sw_irq = 0; tim_irq = 0;
      ack = 0;
   endtask

   task automatic do_ack();
      ack = 1; tick(); ack = 0;
   endtask

   initial begin
      idle_inputs();
      mtvec = 32'h100; mepc_in = 0; pipe_idle = 1;

      // reset state
      #2;
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_redirect", {31'd0, redirect}, 0);
      chk("rst_mcause", mcause, 0);
      chk("rst_raddr", redirect_addr, 0);
      tick(); rst_n = 1; tick();

      // misaligned LOAD word
      stage_en = 1; opcode[OP_LOAD] = 1; funct3 = 3'b010; alu = 32'h1002; pc = 32'h80;
      tick(); idle_inputs();
      chk("ld_stall", {31'd0, stall}, 1);
      chk("ld_mcause", mcause, 4);
      chk("ld_mtval", mtval, 32'h1002);
      chk("ld_mepc", mepc, 32'h80);
      chk("ld_commit0", {31'd0, trap_commit}, 0);
      tick();
      chk("ld_commit1", {31'd0, trap_commit}, 1);
      chk("ld_redir0", {31'd0, redirect}, 0);
      tick();
      chk("ld_commit_end", {31'd0, trap_commit}, 0);
      chk("ld_redir1", {31'd0, redirect}, 1);
      chk("ld_raddr", redirect_addr, 32'h100);
      do_ack();
      chk("ld_redir_clr", {31'd0, redirect}, 0);
      chk("ld_stall_clr", {31'd0, stall}, 0);
      chk("ld_mcause_hold", mcause, 4);

      // byte load at odd address never traps
      stage_en = 1; opcode[OP_LOAD] = 1; funct3 = 3'b000; alu = 32'h3;
      tick(); idle_inputs();
      chk("lb_no_trap", {31'd0, stall}, 0);

      // illegal beats ecall; latency to redirect
      stage_en = 1; opcode[OP_SYSTEM] = 1; illegal = 1; ecall = 1; pc = 32'h90;
      cyc = 0;
      do begin
         tick(); idle_inputs(); cyc++;
      end while (!redirect && cyc < 10);
      chk("ill_latency", cyc, 3);
      chk("ill_mcause", mcause, 2);
      chk("ill_mtval", mtval, 0);
      do_ack();

      // JAL to misaligned target
      stage_en = 1; opcode[OP_JAL] = 1; alu = 32'h102; pc = 32'h94;
      tick(); idle_inputs();
      chk("jal_mcause", mcause, 0);
      chk("jal_mtval", mtval, 32'h102);
      tick(); tick(); do_ack();

      // misaligned store halfword, mtvec base zero -> TRAP_ADDRESS
      mtvec = 32'h0;
      stage_en = 1; opcode[OP_STORE] = 1; funct3 = 3'b001; alu = 32'h3; pc = 32'h98;
      tick(); idle_inputs();
      chk("st_mcause", mcause, 6);
      tick(); tick();
      chk("st_raddr", redirect_addr, 32'h800);
      do_ack();

      // ext + timer pending, vectored mtvec
      mtvec = 32'h201;
      stage_en = 1; mstatus_mie = 1; mie = 3'b111; ext_irq = 1; tim_irq = 1; pc = 32'hC0;
      tick(); idle_inputs();
      chk("irq_mcause", mcause, 32'h8000_000B);
      chk("irq_mepc", mepc, 32'hC0);
      tick(); tick();
      chk("irq_raddr", redirect_addr, 32'h22C);
      do_ack();

      // MRET, no interrupts
      mepc_in = 32'h444;
      stage_en = 1; opcode[OP_SYSTEM] = 1; mret = 1; pc = 32'hA0;
      tick(); idle_inputs();
      chk("mret_stall", {31'd0, stall}, 1);
      chk("mret_commit1", {31'd0, mret_commit}, 1);
      chk("mret_tcommit", {31'd0, trap_commit}, 0);
      tick();
      chk("mret_commit0", {31'd0, mret_commit}, 0);
      chk("mret_redir", {31'd0, redirect}, 1);
      chk("mret_raddr", redirect_addr, 32'h444);
      chk("mret_mcause_hold", mcause, 32'h8000_000B);
      do_ack();

      // MRET with enabled software interrupt: trap wins
      stage_en = 1; opcode[OP_SYSTEM] = 1; mret = 1; pc = 32'hB0;
      mstatus_mie = 1; mie = 3'b001; sw_irq = 1;
      tick(); idle_inputs();
      chk("mret_irq_mcause", mcause, 32'h8000_0003);
      chk("mret_irq_mepc", mepc, 32'hB0);
      chk("mret_irq_no_mcommit", {31'd0, mret_commit}, 0);
      tick();
      chk("mret_irq_tcommit", {31'd0, trap_commit}, 1);
      tick();
      chk("mret_irq_raddr", redirect_addr, 32'h20C);
      do_ack();

      // interrupt drops during a 5-cycle drain
      mtvec = 32'h100; pipe_idle = 0;
      stage_en = 1; mstatus_mie = 1; mie = 3'b100; ext_irq = 1; pc = 32'hD0;
      tick(); idle_inputs();
      for (int i = 0; i < 5; i++) begin
         chk("drain_stall", {31'd0, stall}, 1);
         chk("drain_no_commit", {31'd0, trap_commit}, 0);
         tick();
      end
      pipe_idle = 1;
      tick();
      chk("drain_commit", {31'd0, trap_commit}, 1);
      chk("drain_mcause", mcause, 32'h8000_000B);
      chk("drain_mepc", mepc, 32'hD0);
      tick();
      chk("drain_redir", {31'd0, redirect}, 1);
      chk("drain_raddr", redirect_addr, 32'h100);

      // async reset while in REDIRECT
      rst_n = 0; #1;
      chk("arst_redir", {31'd0, redirect}, 0);
      chk("arst_stall", {31'd0, stall}, 0);
      chk("arst_raddr", redirect_addr, 0);
      chk("arst_mcause", mcause, 0);
      chk("arst_mepc", mepc, 0);
      tick(); rst_n = 1; tick(); tick();
      chk("post_rst_stall", {31'd0, stall}, 0);
      chk("post_rst_redir", {31'd0, redirect}, 0);
      // FSM accepts a new trap from IDLE after release
      stage_en = 1; opcode[OP_SYSTEM] = 1; ebreak = 1; pc = 32'hE4;
      tick(); idle_inputs();
      chk("post_rst_ebreak", mcause, 3);
      chk("post_rst_tval", mtval, 32'hE4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
